// File: rtl/sd_dac_pkg.sv
// rtl/sd_dac_pkg.sv - shared constants and width helpers for the sigma-delta loopback path
package sd_dac_pkg;

    localparam int THERM_WIDTH_D = 7;
    localparam int OUT_WIDTH_D   = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with differential delay 1 is N*log2(R)
    function automatic int acc_width(input int therm_width, input int stages, input int decim_rate);
        return clog2(therm_width + 1) + stages * clog2(decim_rate);
    endfunction

endpackage

// File: rtl/therm_to_bin.sv
// rtl/therm_to_bin.sv - thermometer code to binary count with contiguity flag
module therm_to_bin
    import sd_dac_pkg::*;
#(
    parameter int THERM_WIDTH = THERM_WIDTH_D,
    parameter int COUNT_WIDTH = clog2(THERM_WIDTH + 1)
) (
    input  logic [THERM_WIDTH-1:0] therm,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   is_therm
);

    logic [THERM_WIDTH-1:0] therm_plus1;

    always_comb begin
        count = '0;
        for (int i = 0; i < THERM_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(therm[i]);
        end
    end

    // A valid code is 0..01..1, i.e. therm+1 is a power of two (all-ones wraps to zero)
    assign therm_plus1 = therm + THERM_WIDTH'(1);
    assign is_therm    = ((therm & therm_plus1) == '0);

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - thermometer-input CIC decimator; CIC_DECIMATOR_THERM_CHECK_EN adds sticky therm_err
module cic_decimator
    import sd_dac_pkg::*;
#(
    parameter int THERM_WIDTH     = THERM_WIDTH_D,
    parameter int STAGES          = 3,
    parameter int DECIM_RATE      = 8,
    parameter int OUT_WIDTH       = OUT_WIDTH_D,
    parameter int OUT_SCALE_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [THERM_WIDTH-1:0] therm_in,
    output logic [OUT_WIDTH-1:0]   data_out,
    output logic                   data_valid
`ifdef CIC_DECIMATOR_THERM_CHECK_EN
    ,
    output logic                   therm_err
`endif
);

    localparam int IN_BITS   = clog2(THERM_WIDTH + 1);
    localparam int ACC_WIDTH = acc_width(THERM_WIDTH, STAGES, DECIM_RATE);
    localparam int CNT_WIDTH = clog2(DECIM_RATE);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DECIM_RATE - 1);
    localparam logic [ACC_WIDTH-1:0] OUT_MAX  = ACC_WIDTH'((1 << OUT_WIDTH) - 1);

    logic [IN_BITS-1:0]   sample_cnt;
    logic                 is_therm;
    logic [ACC_WIDTH-1:0] cnt_ext;

    logic [ACC_WIDTH-1:0] integ [STAGES];
    logic [CNT_WIDTH-1:0] decim_cnt;
    logic                 dec_stb;
    logic [ACC_WIDTH-1:0] dec_reg;

    logic [ACC_WIDTH-1:0] comb_dly [STAGES];
    logic [ACC_WIDTH-1:0] comb_in  [STAGES];
    logic [ACC_WIDTH-1:0] comb_acc;
    logic [ACC_WIDTH-1:0] scaled;
    logic [OUT_WIDTH-1:0] sat_val;

    therm_to_bin #(
        .THERM_WIDTH (THERM_WIDTH),
        .COUNT_WIDTH (IN_BITS)
    ) u_therm_to_bin (
        .therm    (therm_in),
        .count    (sample_cnt),
        .is_therm (is_therm)
    );

    assign cnt_ext = ACC_WIDTH'(sample_cnt);

    // Integrators run at input rate and wrap freely; the combs undo the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
            decim_cnt <= '0;
            dec_stb   <= 1'b0;
            dec_reg   <= '0;
        end else begin
            dec_stb <= 1'b0;
            if (enable) begin
                integ[0] <= integ[0] + cnt_ext;
                for (int k = 1; k < STAGES; k++) begin
                    integ[k] <= integ[k] + integ[k-1];
                end
                decim_cnt <= decim_cnt + CNT_WIDTH'(1);
                if (decim_cnt == LAST_CNT) begin
                    dec_stb <= 1'b1;
                    dec_reg <= integ[STAGES-1];
                end
            end
        end
    end

    always_comb begin
        comb_in  = '{default: '0};
        comb_acc = dec_reg;
        for (int k = 0; k < STAGES; k++) begin
            comb_in[k] = comb_acc;
            comb_acc   = comb_acc - comb_dly[k];
        end
    end

    always_comb begin
        scaled  = comb_acc >> OUT_SCALE_SHIFT;
        sat_val = scaled[OUT_WIDTH-1:0];
        if (scaled > OUT_MAX) begin
            sat_val = '1;
        end
    end

    // A pending strobe always completes, even if enable drops after the last sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                comb_dly[k] <= '0;
            end
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= dec_stb;
            if (dec_stb) begin
                for (int k = 0; k < STAGES; k++) begin
                    comb_dly[k] <= comb_in[k];
                end
                data_out <= sat_val;
            end
        end
    end

`ifdef CIC_DECIMATOR_THERM_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_err <= 1'b0;
        end else if (enable && !is_therm) begin
            therm_err <= 1'b1;
        end
    end
`else
    logic unused_is_therm;
    assign unused_is_therm = is_therm;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - directed self-checking bench for cic_decimator
module tb_cic_decimator;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [6:0] therm_in;
    logic [3:0] data_out;
    logic       data_valid;
`ifdef CIC_DECIMATOR_THERM_CHECK_EN
    logic       therm_err;
`endif

    int checks;
    int errors;
    int en_mode;
    int phase;

    cic_decimator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .therm_in   (therm_in),
        .data_out   (data_out),
        .data_valid (data_valid)
`ifdef CIC_DECIMATOR_THERM_CHECK_EN
        ,
        .therm_err  (therm_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        therm_in = '0;
        phase    = 0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    function automatic logic en_of(input int ph);
        if (en_mode == 0) return 1'b1;
        return ((ph % 4) == 0) || ((ph % 4) == 3);
    endfunction

    // Drives enable until the next data_valid; reports value, accepts and cycles since the previous pulse
    task automatic next_pulse(output logic [3:0] val, output int acc, output int cyc, output bit got);
        got = 1'b0;
        acc = 0;
        cyc = 0;
        val = '0;
        for (int i = 0; i < 64 && !got; i++) begin
            enable = en_of(phase);
            phase++;
            if (enable) acc++;
            step();
            cyc++;
            if (data_valid) begin
                got = 1'b1;
                val = data_out;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        therm_in = 7'h7f;
        #3;
        checks++;
        if (data_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_data_out: got %0d expected 0", data_out);
        end
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_data_valid: got %0b expected 0", data_valid);
        end
    endtask

    task automatic test_full_scale();
        logic [3:0] v;
        int acc, cyc;
        bit got;
        logic [3:0] exp_v [6] = '{4'd0, 4'd9, 4'd13, 4'd14, 4'd14, 4'd14};
        do_reset();
        en_mode  = 0;
        therm_in = 7'b1111111;
        for (int p = 0; p < 6; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL full_scale_timeout: pulse %0d not seen within 64 cycles", p);
            end else if (v !== exp_v[p]) begin
                errors++;
                $display("FAIL full_scale_value: pulse %0d got %0d expected %0d", p, v, exp_v[p]);
            end
            if (p > 0) begin
                checks++;
                if (cyc !== 8) begin
                    errors++;
                    $display("FAIL full_scale_spacing: pulse %0d got %0d cycles expected 8", p, cyc);
                end
            end
        end
    endtask

    task automatic test_other_codes();
        logic [3:0] v;
        int acc, cyc;
        bit got;
        logic [3:0] exp4 [5] = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd8};
        logic [3:0] exp2 [5] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd4};
        do_reset();
        en_mode  = 0;
        therm_in = 7'b0001111;
        for (int p = 0; p < 5; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got || v !== exp4[p]) begin
                errors++;
                $display("FAIL count4_value: pulse %0d got %0d (seen %0b) expected %0d", p, v, got, exp4[p]);
            end
        end
        do_reset();
        therm_in = 7'b0000000;
        for (int p = 0; p < 4; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got || v !== 4'd0) begin
                errors++;
                $display("FAIL zero_value: pulse %0d got %0d (seen %0b) expected 0", p, v, got);
            end
        end
        // Non-contiguous code still converts by popcount (2)
        do_reset();
        therm_in = 7'b0000101;
        for (int p = 0; p < 5; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got || v !== exp2[p]) begin
                errors++;
                $display("FAIL noncontig_value: pulse %0d got %0d (seen %0b) expected %0d", p, v, got, exp2[p]);
            end
        end
    endtask

    task automatic test_latency();
        int early;
        do_reset();
        therm_in = 7'b1111111;
        enable   = 1'b1;
        early    = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (data_valid) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL latency_early: data_valid high %0d times expected 0", early);
        end
        enable = 1'b0;
        step();
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_second_cycle: data_valid %0b expected 1", data_valid);
        end
        checks++;
        if (data_out !== 4'd0) begin
            errors++;
            $display("FAIL latency_first_value: got %0d expected 0", data_out);
        end
        step();
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_width: data_valid %0b expected 0", data_valid);
        end
        early = 0;
        repeat (20) begin
            step();
            if (data_valid) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL hold_no_pulse: data_valid high %0d times expected 0", early);
        end
    endtask

    task automatic test_enable_toggle();
        logic [3:0] v;
        int acc, cyc;
        bit got;
        logic [3:0] exp_v [5] = '{4'd0, 4'd9, 4'd13, 4'd14, 4'd14};
        do_reset();
        en_mode  = 1;
        therm_in = 7'b1111111;
        for (int p = 0; p < 5; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got || v !== exp_v[p]) begin
                errors++;
                $display("FAIL toggle_value: pulse %0d got %0d (seen %0b) expected %0d", p, v, got, exp_v[p]);
            end
            if (p > 0) begin
                checks++;
                if (acc !== 8) begin
                    errors++;
                    $display("FAIL toggle_accepts: pulse %0d got %0d accepts expected 8", p, acc);
                end
            end
        end
        en_mode = 0;
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] v;
        int acc, cyc;
        bit got;
        logic [3:0] exp_v [5] = '{4'd0, 4'd9, 4'd13, 4'd14, 4'd14};
        do_reset();
        en_mode  = 0;
        therm_in = 7'b1111111;
        for (int p = 0; p < 500; p++) begin
            next_pulse(v, acc, cyc, got);
            if (p >= 3) begin
                checks++;
                if (!got || v !== 4'd14 || cyc !== 8) begin
                    errors++;
                    $display("FAIL wrap_steady: pulse %0d got %0d after %0d cycles expected 14 after 8", p, v, cyc);
                end
            end
        end
        enable = 1'b1;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data_out !== 4'd0 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: data_out %0d data_valid %0b expected 0 0", data_out, data_valid);
        end
        step();
        rst_n = 1'b1;
        phase = 0;
        for (int p = 0; p < 5; p++) begin
            next_pulse(v, acc, cyc, got);
            checks++;
            if (!got || v !== exp_v[p]) begin
                errors++;
                $display("FAIL resettle_value: pulse %0d got %0d (seen %0b) expected %0d", p, v, got, exp_v[p]);
            end
        end
    endtask

`ifdef CIC_DECIMATOR_THERM_CHECK_EN
    task automatic test_therm_check();
        do_reset();
        checks++;
        if (therm_err !== 1'b0) begin
            errors++;
            $display("FAIL therm_err_reset: got %0b expected 0", therm_err);
        end
        therm_in = 7'b0000101;
        enable   = 1'b0;
        repeat (3) step();
        checks++;
        if (therm_err !== 1'b0) begin
            errors++;
            $display("FAIL therm_err_disabled: got %0b expected 0", therm_err);
        end
        enable = 1'b1;
        step();
        checks++;
        if (therm_err !== 1'b1) begin
            errors++;
            $display("FAIL therm_err_set: got %0b expected 1", therm_err);
        end
        therm_in = 7'b0000111;
        repeat (5) step();
        checks++;
        if (therm_err !== 1'b1) begin
            errors++;
            $display("FAIL therm_err_sticky: got %0b expected 1", therm_err);
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        en_mode  = 0;
        phase    = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        therm_in = '0;
        test_reset();
        test_full_scale();
        test_other_codes();
        test_latency();
        test_enable_toggle();
        test_wrap_and_reset();
`ifdef CIC_DECIMATOR_THERM_CHECK_EN
        test_therm_check();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
